// File: rtl/mux_scan_sel.sv
// Registered NUM_CH:1 multiplexer with manual select or round-robin scan and a programmable dwell.
// Optional per-channel scan enable mask: define MUX_SCAN_MASK_EN to add the ch_mask port.
module mux_scan_sel #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int unsigned DWELL_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] din,
  input  logic                    en,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel_in,
  input  logic [DWELL_W-1:0]      dwell,
`ifdef MUX_SCAN_MASK_EN
  input  logic [NUM_CH-1:0]       ch_mask,
`endif
  output logic [WIDTH-1:0]        dout,
  output logic [SEL_W-1:0]        sel_out,
  output logic                    valid,
  output logic                    wrap
);

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  state_t             state, state_d;
  logic [SEL_W-1:0]   ch, ch_d;
  logic [DWELL_W-1:0] cnt, cnt_d;
  logic               wpend, wpend_d;
  logic [WIDTH-1:0]   dout_d;
  logic [SEL_W-1:0]   sel_d;
  logic               valid_d, wrap_d;
  logic [NUM_CH-1:0]  mask;
  logic [SEL_W-1:0]   eff_ch, nxt;
  logic [DWELL_W-1:0] eff_cnt;

`ifdef MUX_SCAN_MASK_EN
  assign mask = ch_mask;
`else
  assign mask = '1;
`endif

  // Out-of-range indices yield zero.
  function automatic logic [WIDTH-1:0] pick(input logic [NUM_CH*WIDTH-1:0] bus,
                                            input logic [SEL_W-1:0] idx);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < NUM_CH; k++)
      if (SEL_W'(k) == idx) r = bus[k*WIDTH +: WIDTH];
    return r;
  endfunction

  // Next enabled channel after c, searched cyclically; c itself if it is the only one.
  function automatic logic [SEL_W-1:0] next_en(input logic [SEL_W-1:0] c,
                                               input logic [NUM_CH-1:0] m);
    logic [SEL_W-1:0] r;
    logic             found;
    int unsigned      j;
    r     = c;
    found = 1'b0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      j = (32'(c) + i) % NUM_CH;
      if (!found && m[j]) begin
        r     = SEL_W'(j);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Outside SCAN, ch/cnt are held at 0, so the scan entry edge naturally starts
  // from channel 0 (or the lowest enabled channel when the mask excludes 0).
  always_comb begin
    state_d = state;
    dout_d  = dout;
    sel_d   = sel_out;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    ch_d    = '0;
    cnt_d   = '0;
    wpend_d = 1'b0;
    eff_ch  = ch;
    eff_cnt = cnt;
    nxt     = ch;
    if (!en) begin
      state_d = IDLE;
    end else if (!mode) begin
      state_d = MANUAL;
      dout_d  = pick(din, sel_in);
      sel_d   = sel_in;
      valid_d = (32'(sel_in) < NUM_CH);
    end else begin
      state_d = SCAN;
      if (mask != '0) begin
        if (!mask[ch]) begin
          eff_ch  = next_en(ch, mask);
          eff_cnt = '0;
        end
        dout_d  = pick(din, eff_ch);
        sel_d   = eff_ch;
        valid_d = 1'b1;
        wrap_d  = (state == SCAN) && wpend;
        if (eff_cnt >= dwell) begin
          nxt     = next_en(eff_ch, mask);
          ch_d    = nxt;
          wpend_d = (nxt <= eff_ch);
        end else begin
          ch_d  = eff_ch;
          cnt_d = eff_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ch      <= '0;
      cnt     <= '0;
      wpend   <= 1'b0;
      dout    <= '0;
      sel_out <= '0;
      valid   <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state   <= state_d;
      ch      <= ch_d;
      cnt     <= cnt_d;
      wpend   <= wpend_d;
      dout    <= dout_d;
      sel_out <= sel_d;
      valid   <= valid_d;
      wrap    <= wrap_d;
    end
  end

endmodule

// File: tb/tb_mux_scan_sel.sv
// Directed table-driven bench for mux_scan_sel (NUM_CH=4, WIDTH=8).
module tb_mux_scan_sel;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] din;
  logic        en, mode;
  logic [1:0]  sel_in;
  logic [7:0]  dwell;
`ifdef MUX_SCAN_MASK_EN
  logic [3:0]  ch_mask;
`endif
  logic [7:0]  dout;
  logic [1:0]  sel_out;
  logic        valid, wrap;

  int tests = 0;
  int fails = 0;

  mux_scan_sel #(.NUM_CH(4), .WIDTH(8), .DWELL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .en(en), .mode(mode),
    .sel_in(sel_in), .dwell(dwell),
`ifdef MUX_SCAN_MASK_EN
    .ch_mask(ch_mask),
`endif
    .dout(dout), .sel_out(sel_out), .valid(valid), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n, en, mode;
    logic [1:0] sel;
    logic [7:0] dwell;
    logic [7:0] x_dout;
    logic [1:0] x_sel;
    logic       x_valid, x_wrap;
  } vec_t;

  vec_t v[21];

  task automatic check(input string name, input int idx, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic e, input logic m, input logic [1:0] s,
                       input logic [7:0] d);
    rst_n = r; en = e; mode = m; sel_in = s; dwell = d;
  endtask

  int nwrap;

  initial begin
    din = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
`ifdef MUX_SCAN_MASK_EN
    ch_mask = 4'hF;
`endif
    //        rst en md sel dwell  dout   sel vld wrp
    v[0]  = '{0, 0, 0, 0, 8'd0, 8'h00, 0, 0, 0};
    v[1]  = '{1, 1, 0, 2, 8'd0, 8'hCC, 2, 1, 0};
    v[2]  = '{1, 1, 0, 3, 8'd0, 8'hDD, 3, 1, 0};
    v[3]  = '{1, 1, 0, 1, 8'd0, 8'hBB, 1, 1, 0};
    v[4]  = '{1, 1, 1, 0, 8'd0, 8'hAA, 0, 1, 0};
    v[5]  = '{1, 1, 1, 0, 8'd0, 8'hBB, 1, 1, 0};
    v[6]  = '{1, 1, 1, 0, 8'd0, 8'hCC, 2, 1, 0};
    v[7]  = '{1, 1, 1, 0, 8'd0, 8'hDD, 3, 1, 0};
    v[8]  = '{1, 1, 1, 0, 8'd0, 8'hAA, 0, 1, 1};
    v[9]  = '{1, 1, 1, 0, 8'd0, 8'hBB, 1, 1, 0};
    v[10] = '{1, 0, 1, 0, 8'd0, 8'hBB, 1, 0, 0};
    v[11] = '{1, 1, 1, 0, 8'd0, 8'hAA, 0, 1, 0};
    v[12] = '{0, 1, 1, 0, 8'd0, 8'h00, 0, 0, 0};
    v[13] = '{1, 1, 1, 0, 8'd2, 8'hAA, 0, 1, 0};
    v[14] = '{1, 1, 1, 0, 8'd2, 8'hAA, 0, 1, 0};
    v[15] = '{1, 1, 1, 0, 8'd2, 8'hAA, 0, 1, 0};
    v[16] = '{1, 1, 1, 0, 8'd2, 8'hBB, 1, 1, 0};
    v[17] = '{1, 1, 1, 0, 8'd0, 8'hBB, 1, 1, 0};
    v[18] = '{1, 1, 1, 0, 8'd0, 8'hCC, 2, 1, 0};
    v[19] = '{1, 1, 1, 0, 8'd0, 8'hDD, 3, 1, 0};
    v[20] = '{1, 1, 1, 0, 8'd0, 8'hAA, 0, 1, 1};

    // Some activity before the first reset row.
    drive(1, 1, 0, 3, 8'd0);
    step();

    for (int i = 0; i < 21; i++) begin
      drive(v[i].rst_n, v[i].en, v[i].mode, v[i].sel, v[i].dwell);
      step();
      check("dout",    i, int'(dout),    int'(v[i].x_dout));
      check("sel_out", i, int'(sel_out), int'(v[i].x_sel));
      check("valid",   i, int'(valid),   int'(v[i].x_valid));
      check("wrap",    i, int'(wrap),    int'(v[i].x_wrap));
    end

    // dout follows a data change within one dwell period.
    drive(0, 0, 0, 0, 8'd0);
    step();
    drive(1, 1, 1, 0, 8'd3);
    step();
    check("track_pre", 0, int'(dout), 8'hAA);
    din[7:0] = 8'h11;
    step();
    check("track_dout", 0, int'(dout), 8'h11);
    check("track_sel",  0, int'(sel_out), 0);
    din[7:0] = 8'hAA;

    // dwell=1: 8-edge cycle, wrap on edges 9 and 17 after entry, one cycle wide each.
    drive(0, 0, 0, 0, 8'd0);
    step();
    nwrap = 0;
    drive(1, 1, 1, 0, 8'd1);
    for (int e = 1; e <= 24; e++) begin
      step();
      if (wrap) begin
        nwrap++;
        check("wrap_edge", e, e, (nwrap == 1) ? 9 : 17);
        check("wrap_sel",  e, int'(sel_out), 0);
      end
    end
    check("wrap_count", 0, nwrap, 2);

`ifdef MUX_SCAN_MASK_EN
    drive(0, 0, 0, 0, 8'd0);
    step();
    ch_mask = 4'b1010;
    drive(1, 1, 1, 0, 8'd0);
    step();
    check("mask_dout0", 0, int'(dout), 8'hBB);
    check("mask_wrap0", 0, int'(wrap), 0);
    step();
    check("mask_dout1", 1, int'(dout), 8'hDD);
    check("mask_wrap1", 1, int'(wrap), 0);
    step();
    check("mask_dout2", 2, int'(dout), 8'hBB);
    check("mask_wrap2", 2, int'(wrap), 1);
    ch_mask = 4'b0000;
    step();
    check("mask_zero_valid", 3, int'(valid), 0);
    check("mask_zero_dout",  3, int'(dout), 8'hBB);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
